// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the folded approximate multiplier.
// Tile width, FSM state encoding, and the weight of a nibble pair.
package approx_mult_pkg;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [4:0] tile_weight(input logic [3:0] i, input logic [3:0] j);
    return 5'(i) + 5'(j);
  endfunction

endpackage

// File: rtl/approx_tile_4x4.sv
// Combinational 4x4 unsigned tile multiplier.
// When trunc_en is set, the low TRUNC_BITS bits of the product read as zero.
module approx_tile_4x4 #(
  parameter int TRUNC_BITS = 2
) (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       trunc_en,
  output logic [7:0] p
);

  localparam logic [7:0] KEEP_MASK = ~((8'd1 << TRUNC_BITS) - 8'd1);

  logic [7:0] prod;

  always_comb begin
    prod = 8'(x) * 8'(y);
    p    = trunc_en ? (prod & KEEP_MASK) : prod;
  end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential approximate multiplier: one 4x4 tile per cycle, shifted and accumulated.
// Optional macro OR_ACCUM_EN merges approximate tiles with OR instead of addition.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | accumulating one tile per cycle
// DONE  | result valid, waiting for out_ready
module approx_mult_seq
  import approx_mult_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int EXACT_WEIGHT = 1,
  parameter int TRUNC_BITS   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   r,
  output logic                 busy
);

  localparam int         K      = WIDTH / TILE_W;
  localparam int         ACC_W  = 2 * WIDTH;
  localparam logic [3:0] K_LAST = 4'(K - 1);
  localparam int         EW_C   = (EXACT_WEIGHT > 31) ? 31 : EXACT_WEIGHT;
  localparam logic [4:0] EW     = 5'(EW_C);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d, r_q, r_d;
  logic [3:0]         i_q, i_d, j_q, j_d;

  logic [3:0]         a_nib, b_nib;
  logic [7:0]         tile_p;
  logic [4:0]         weight;
  logic               approx;
  logic [ACC_W-1:0]   shifted, acc_next;

  assign weight  = tile_weight(i_q, j_q);
  assign approx  = (weight < EW);
  assign a_nib   = 4'(a_q >> {i_q, 2'b00});
  assign b_nib   = 4'(b_q >> {j_q, 2'b00});
  assign shifted = ACC_W'(tile_p) << {weight, 2'b00};

  approx_tile_4x4 #(.TRUNC_BITS(TRUNC_BITS)) u_tile (
    .x        (a_nib),
    .y        (b_nib),
    .trunc_en (approx),
    .p        (tile_p)
  );

`ifdef OR_ACCUM_EN
  assign acc_next = approx ? (acc_q | shifted) : (acc_q + shifted);
`else
  assign acc_next = acc_q + shifted;
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign r         = r_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    r_d     = r_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE, DONE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = CALC;
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = acc_next;
        if (j_q == K_LAST) begin
          j_d = '0;
          if (i_q == K_LAST) begin
            i_d     = '0;
            r_d     = acc_next;
            state_d = DONE;
          end else begin
            i_d = i_q + 4'd1;
          end
        end else begin
          j_d = j_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

endmodule
